// File: rtl/adc_link_pkg.sv
// Shared definitions for the ADC host link: frame packer states, framing constants
// and host command codes used by the packer and the command parser.
package adc_link_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSyncA,
        StSyncB,
        StLenL,
        StLenH,
        StRdReq,
        StRdWait,
        StDatL,
        StDatH,
        StCsum,
        StDone
    } packerState_t;

    localparam logic [7:0]  SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0]  SYNC1_DEFAULT = 8'h5A;
    localparam int unsigned FRAME_HDR_LEN = 4;

    typedef enum logic [7:0] {
        CmdNop     = 8'h00,
        CmdArm     = 8'h01,
        CmdAbort   = 8'h02,
        CmdReadout = 8'h03,
        CmdStatus  = 8'h04
    } hostCmd_t;

endpackage

// File: rtl/adc_frame_packer.sv
// Reads the captured sample RAM and emits a framed, handshaked byte stream for the FT245
// driver. Define FRAME_CHECKSUM_EN to append an XOR checksum byte after the payload.
module adc_frame_packer
    import adc_link_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  SYNC0  = SYNC0_DEFAULT,
    parameter logic [7:0]  SYNC1  = SYNC1_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    output logic [ADDR_W-1:0] RAM_RD_ADDR,
    input  logic [15:0]       RAM_RD_DATA,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              BUSY,
    output logic              FRAME_DONE
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    packerState_t      stateQ, stateD;
    logic [15:0]       lenQ, lenD;
    logic [ADDR_W-1:0] lastAddrQ, lastAddrD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [15:0]       wordQ, wordD;
    logic              xfer;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csumQ, csumD;
`endif

    assign xfer        = TX_VALID && TX_READY;
    assign RAM_RD_ADDR = addrQ;

    always_comb begin
        stateD    = stateQ;
        lenD      = lenQ;
        lastAddrD = lastAddrQ;
        addrD     = addrQ;
        wordD     = wordQ;
        unique case (stateQ)
            StIdle: begin
                if (START) begin
                    lenD      = 16'(LAST_ADDR) + 16'd1;
                    lastAddrD = LAST_ADDR;
                    addrD     = '0;
                    stateD    = StSyncA;
                end
            end
            StSyncA: if (xfer) stateD = StSyncB;
            StSyncB: if (xfer) stateD = StLenL;
            StLenL:  if (xfer) stateD = StLenH;
            StLenH:  if (xfer) stateD = StRdReq;
            StRdReq: stateD = StRdWait;
            StRdWait: begin
                wordD  = RAM_RD_DATA;
                stateD = StDatL;
            end
            StDatL:  if (xfer) stateD = StDatH;
            StDatH: begin
                if (xfer) begin
                    if (addrQ == lastAddrQ) begin
`ifdef FRAME_CHECKSUM_EN
                        stateD = StCsum;
`else
                        stateD = StDone;
`endif
                    end else begin
                        addrD  = addrQ + ADDR_ONE;
                        stateD = StRdReq;
                    end
                end
            end
            StCsum:  if (xfer) stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Outputs decode straight from registered state so TX_DATA holds while stalled.
    always_comb begin
        TX_VALID = 1'b0;
        TX_DATA  = 8'h00;
        unique case (stateQ)
            StSyncA: begin TX_VALID = 1'b1; TX_DATA = SYNC0;        end
            StSyncB: begin TX_VALID = 1'b1; TX_DATA = SYNC1;        end
            StLenL:  begin TX_VALID = 1'b1; TX_DATA = lenQ[7:0];    end
            StLenH:  begin TX_VALID = 1'b1; TX_DATA = lenQ[15:8];   end
            StDatL:  begin TX_VALID = 1'b1; TX_DATA = wordQ[7:0];   end
            StDatH:  begin TX_VALID = 1'b1; TX_DATA = wordQ[15:8];  end
`ifdef FRAME_CHECKSUM_EN
            StCsum:  begin TX_VALID = 1'b1; TX_DATA = csumQ;        end
`endif
            default: begin TX_VALID = 1'b0; TX_DATA = 8'h00;        end
        endcase
    end

    assign BUSY       = (stateQ != StIdle) && (stateQ != StDone);
    assign FRAME_DONE = (stateQ == StDone);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ    <= StIdle;
            lenQ      <= '0;
            lastAddrQ <= '0;
            addrQ     <= '0;
            wordQ     <= '0;
        end else begin
            stateQ    <= stateD;
            lenQ      <= lenD;
            lastAddrQ <= lastAddrD;
            addrQ     <= addrD;
            wordQ     <= wordD;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Sync bytes are excluded; the running XOR covers length and payload only.
    always_comb begin
        csumD = csumQ;
        if (stateQ == StIdle && START) begin
            csumD = '0;
        end else if (xfer && (stateQ inside {StLenL, StLenH, StDatL, StDatH})) begin
            csumD = csumQ ^ TX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            csumQ <= '0;
        end else begin
            csumQ <= csumD;
        end
    end
`endif

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: a frame-level reference model predicts every byte, the done
// pulse and BUSY; directed tests pin the model with literal frames. Honours FRAME_CHECKSUM_EN.
module tb_adc_frame_packer;

`ifdef FRAME_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [9:0]  LAST_ADDR;
    logic [9:0]  RAM_RD_ADDR;
    logic [15:0] ramRdData = 16'h0000;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic        BUSY;
    logic        FRAME_DONE;

    logic [15:0] ram [0:1023];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          readyRandom = 1'b0;

    // Reference model state (owned by the monitor process)
    logic [7:0]  expQ[$];
    logic [7:0]  gotQ[$];
    bit          modelBusy = 1'b0;
    bit          doneDue = 1'b0;
    bit          stallPrev = 1'b0;
    logic [7:0]  stallData = 8'h00;
    int          doneCount = 0;
    int          startCyc = 0;
    int          doneCyc = 0;
    logic [9:0]  doneAddr = '0;

    adc_frame_packer #(
        .ADDR_W(10),
        .SYNC0 (8'hA5),
        .SYNC1 (8'h5A)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .LAST_ADDR  (LAST_ADDR),
        .RAM_RD_ADDR(RAM_RD_ADDR),
        .RAM_RD_DATA(ramRdData),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // One-cycle-latency synchronous sample RAM
    always @(posedge CLK) ramRdData <= ram[RAM_RD_ADDR];

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            TX_READY = readyRandom ? 1'($urandom & 1) : 1'b1;
        end
    end

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
        end
    endfunction

    function automatic void buildFrame(input logic [9:0] la);
        logic [15:0] len;
        logic [15:0] w;
        logic [7:0]  cs;
        len = 16'(la) + 16'd1;
        expQ.push_back(8'hA5);
        expQ.push_back(8'h5A);
        expQ.push_back(len[7:0]);
        expQ.push_back(len[15:8]);
        cs = len[7:0] ^ len[15:8];
        for (int i = 0; i <= int'(la); i++) begin
            w = ram[i];
            expQ.push_back(w[7:0]);
            expQ.push_back(w[15:8]);
            cs = cs ^ w[7:0] ^ w[15:8];
        end
        if (CSUM_BYTES == 1) expQ.push_back(cs);
    endfunction

    // Compare process: checks every cycle against the frame-level model
    always @(negedge CLK) begin
        if (RST) begin
            expQ.delete();
            modelBusy = 1'b0;
            doneDue   = 1'b0;
            stallPrev = 1'b0;
        end else begin
            chk("busy", 32'(BUSY), 32'(modelBusy && !doneDue));
            chk("frame_done", 32'(FRAME_DONE), 32'(doneDue));
            if (!modelBusy) chk("idle_valid", 32'(TX_VALID), 0);
            if (stallPrev) begin
                chk("stall_valid", 32'(TX_VALID), 1);
                chk("stall_data", 32'(TX_DATA), 32'(stallData));
            end
            if (doneDue) begin
                doneCount++;
                doneCyc   = cyc;
                doneAddr  = RAM_RD_ADDR;
                modelBusy = 1'b0;
                doneDue   = 1'b0;
            end else if (START && !modelBusy) begin
                buildFrame(LAST_ADDR);
                modelBusy = 1'b1;
                startCyc  = cyc;
            end
            if (TX_VALID && TX_READY) begin
                gotQ.push_back(TX_DATA);
                chk("byte_expected", 32'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    chk("tx_byte", 32'(TX_DATA), 32'(expQ.pop_front()));
                    if (expQ.size() == 0 && modelBusy) doneDue = 1'b1;
                end
            end
            stallPrev = TX_VALID && !TX_READY;
            stallData = TX_DATA;
        end
    end

    task automatic startFrame(input logic [9:0] la);
        @(posedge CLK);
        #1;
        START     = 1'b1;
        LAST_ADDR = la;
        @(posedge CLK);
        #1;
        START     = 1'b0;
        LAST_ADDR = 10'($urandom);
    endtask

    task automatic waitDone(input int target, input int budget);
        int c;
        c = 0;
        while (doneCount < target && c < budget) begin
            @(posedge CLK);
            c++;
        end
        chk("done_in_time", 32'(doneCount >= target), 1);
    endtask

    task automatic checkSeq(input string nm, input int base, input logic [7:0] lit [$]);
        chk({nm, "_count"}, 32'(gotQ.size() - base), 32'(lit.size()));
        for (int i = 0; i < lit.size(); i++) begin
            if (base + i < gotQ.size()) chk(nm, 32'(gotQ[base + i]), 32'(lit[i]));
        end
    endtask

    initial begin
        logic [7:0] lit [$];
        int base;
        int nd;
        bit hit;

        RST = 1'b1;
        START = 1'b0;
        LAST_ADDR = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_valid", 32'(TX_VALID), 0);
        chk("rst_data", 32'(TX_DATA), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_done", 32'(FRAME_DONE), 0);
        chk("rst_addr", 32'(RAM_RD_ADDR), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Two-word frame at full rate, literal bytes
        ram[0] = 16'h1234;
        ram[1] = 16'hABCD;
        lit = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB};
        if (CSUM_BYTES == 1) lit.push_back(8'h42);
        base = gotQ.size();
        nd = doneCount;
        startFrame(10'd1);
        waitDone(nd + 1, 200);
        checkSeq("frame2w", base, lit);

        // Same frame under random backpressure
        readyRandom = 1'b1;
        base = gotQ.size();
        nd = doneCount;
        startFrame(10'd1);
        waitDone(nd + 1, 400);
        checkSeq("frame2w_bp", base, lit);
        readyRandom = 1'b0;

        // Single word: latency from START cycle to FRAME_DONE cycle
        ram[0] = 16'($urandom);
        nd = doneCount;
        startFrame(10'd0);
        waitDone(nd + 1, 100);
        chk("single_latency", 32'(doneCyc - startCyc), 32'(9 + CSUM_BYTES));
        chk("single_addr", 32'(doneAddr), 0);

        // Maximum length frame
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i);
        base = gotQ.size();
        nd = doneCount;
        startFrame(10'd1023);
        waitDone(nd + 1, 6000);
        chk("max_count", 32'(gotQ.size() - base), 32'(4 + 2048 + CSUM_BYTES));
        if (gotQ.size() >= base + 4 + 2048) begin
            chk("max_len_lo", 32'(gotQ[base + 2]), 32'h00);
            chk("max_len_hi", 32'(gotQ[base + 3]), 32'h04);
            chk("max_last_lo", 32'(gotQ[base + 4 + 2046]), 32'hFF);
            chk("max_last_hi", 32'(gotQ[base + 4 + 2047]), 32'h03);
        end
        chk("max_end_addr", 32'(doneAddr), 32'd1023);

        // START while busy (3rd payload byte) and in the DONE cycle
        for (int i = 0; i < 4; i++) ram[i] = 16'($urandom);
        base = gotQ.size();
        nd = doneCount;
        startFrame(10'd3);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge CLK);
            #2;
            if (gotQ.size() - base == 6 && TX_VALID) begin
                hit = 1'b1;
                START = 1'b1;
                LAST_ADDR = 10'd9;
                @(posedge CLK);
                #1;
                START = 1'b0;
            end
        end
        chk("busy_start_reached", 32'(hit), 1);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge CLK);
            #2;
            if (FRAME_DONE) begin
                hit = 1'b1;
                START = 1'b1;
                @(posedge CLK);
                #1;
                START = 1'b0;
            end
        end
        chk("done_start_reached", 32'(hit), 1);
        repeat (12) @(posedge CLK);
        chk("one_frame_only", 32'(doneCount - nd), 1);
        chk("one_frame_bytes", 32'(gotQ.size() - base), 32'(4 + 8 + CSUM_BYTES));
        chk("idle_after", 32'(BUSY), 0);

        // Reset during DAT_L of word 5, then a fresh single-word frame
        for (int i = 0; i < 8; i++) ram[i] = 16'($urandom);
        base = gotQ.size();
        startFrame(10'd7);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge CLK);
            #2;
            if (gotQ.size() - base == 14 && TX_VALID) hit = 1'b1;
        end
        chk("rst_mid_reached", 32'(hit), 1);
        nd = doneCount;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_mid_valid", 32'(TX_VALID), 0);
        chk("rst_mid_busy", 32'(BUSY), 0);
        chk("rst_mid_done", 32'(FRAME_DONE), 0);
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        chk("rst_mid_no_done", 32'(doneCount - nd), 0);
        ram[0] = 16'h00FF;
        lit = '{8'hA5, 8'h5A, 8'h01, 8'h00, 8'hFF, 8'h00};
        if (CSUM_BYTES == 1) lit.push_back(8'hFE);
        base = gotQ.size();
        nd = doneCount;
        startFrame(10'd0);
        waitDone(nd + 1, 100);
        checkSeq("after_rst", base, lit);

        // Random frames under random backpressure
        readyRandom = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int la;
            la = int'($urandom_range(0, 20));
            for (int i = 0; i <= la; i++) ram[i] = 16'($urandom);
            nd = doneCount;
            startFrame(10'(la));
            waitDone(nd + 1, 1000);
            chk("rand_end_addr", 32'(doneAddr), 32'(la));
        end
        readyRandom = 1'b0;

        repeat (5) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
